// File: rtl/battleship_turn_ctrl.sv
// battleship_turn_ctrl
//   Game sequencer for two-player Battleship on a CELLS-cell grid. It takes
//   the game through fleet placement for A and then B, and then alternating
//   turns. It drives load/fire strobes, a one-hot target and a fleet bitmap
//   into the two per-fleet hit_or_miss datapaths. It also tracks shot history,
//   per-player shot/hit counts and the winner.
//
// Parameters
//   CELLS       grid cells; width of target/fleet/history vectors
//   RESULT_LAT  cycles from a fire strobe until board_x reflects the shot (>=1)
//   HIT_AGAIN   1: shooter keeps the turn after a hit; 0: turn always alternates
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   place_req   pulse: commit fleet_in for the player being placed
//   fleet_in    fleet bitmap from the placement UI
//   fire_req    pulse: fire at target_in
//   target_in   requested target, must be one-hot
//   new_game    pulse: restart, honoured only in GAMEOVER
//   board_a/b   remaining ships of fleet A/B
//   load_a/b    1-cycle place strobe to instance A/B
//   fire_a/b    1-cycle fire strobe to instance A/B (A's fleet is shot by B)
//   target_out  registered target, stable from the fire strobe to RESOLVE
//   fleet_out   registered fleet, valid while load_a/b is high
//   turn        0 = A shooting, 1 = B shooting
//   last_hit    1-cycle pulse in RESOLVE on a hit
//   last_miss   1-cycle pulse in RESOLVE on a miss
//   shot_err    1-cycle pulse when a place/fire request is rejected
//   shots_a/b   shots taken by A/B
//   hits_a/b    hits scored by A/B
//   winner      00 none, 01 A won, 10 B won
//   phase       current state encoding
module battleship_turn_ctrl #(
    parameter int unsigned CELLS      = 36,
    parameter int unsigned RESULT_LAT = 2,
    parameter bit          HIT_AGAIN  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             place_req,
    input  logic [CELLS-1:0] fleet_in,
    input  logic             fire_req,
    input  logic [CELLS-1:0] target_in,
    input  logic             new_game,
    input  logic [CELLS-1:0] board_a,
    input  logic [CELLS-1:0] board_b,
    output logic             load_a,
    output logic             load_b,
    output logic             fire_a,
    output logic             fire_b,
    output logic [CELLS-1:0] target_out,
    output logic [CELLS-1:0] fleet_out,
    output logic             turn,
    output logic             last_hit,
    output logic             last_miss,
    output logic             shot_err,
    output logic [5:0]       shots_a,
    output logic [5:0]       shots_b,
    output logic [5:0]       hits_a,
    output logic [5:0]       hits_b,
    output logic [1:0]       winner,
    output logic [2:0]       phase
);

    localparam int unsigned LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    typedef enum logic [2:0] {
        PLACE_A  = 3'd0,
        PLACE_B  = 3'd1,
        TURN     = 3'd2,
        FIRE     = 3'd3,
        WAIT     = 3'd4,
        RESOLVE  = 3'd5,
        GAMEOVER = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CELLS-1:0] hist_a;
    logic [CELLS-1:0] hist_b;
    logic [CELLS-1:0] snap;
    logic [LW-1:0]    lat_cnt;

    logic [CELLS-1:0] hist_cur;
    logic [CELLS-1:0] victim_live;
    logic [CELLS-1:0] tgt_m1;
    logic             one_hot;
    logic             hit;
    logic             sunk_all;
    logic             place_ok;
    logic             place_bad;
    logic             fire_ok;
    logic             fire_bad;

    assign hist_cur    = turn ? hist_b : hist_a;
    assign victim_live = turn ? board_a : board_b;
    assign tgt_m1      = target_in - CELLS'(1);
    // x & (x-1) clears the lowest set bit, so it is zero only for a single bit.
    assign one_hot     = (target_in != '0) && ((target_in & tgt_m1) == '0);
    // Hit is judged against the board captured at accept time, because the
    // live board has already had the shot cell removed by now.
    assign hit         = |(target_out & snap);
    assign sunk_all    = (victim_live == '0);
    assign phase       = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PLACE_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        place_ok  = 1'b0;
        place_bad = 1'b0;
        fire_ok   = 1'b0;
        fire_bad  = 1'b0;
        fire_a    = 1'b0;
        fire_b    = 1'b0;
        last_hit  = 1'b0;
        last_miss = 1'b0;
        case (state)
            PLACE_A: begin
                if (place_req) begin
                    if (fleet_in != '0) begin
                        place_ok  = 1'b1;
                        state_nxt = PLACE_B;
                    end else begin
                        place_bad = 1'b1;
                    end
                end
            end
            PLACE_B: begin
                if (place_req) begin
                    if (fleet_in != '0) begin
                        place_ok  = 1'b1;
                        state_nxt = TURN;
                    end else begin
                        place_bad = 1'b1;
                    end
                end
            end
            TURN: begin
                if (fire_req) begin
                    if (one_hot && ((target_in & hist_cur) == '0)) begin
                        fire_ok   = 1'b1;
                        state_nxt = FIRE;
                    end else begin
                        fire_bad  = 1'b1;
                    end
                end
            end
            FIRE: begin
                fire_a    = turn;
                fire_b    = ~turn;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LW'(RESULT_LAT - 1)) begin
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                last_hit  = hit;
                last_miss = ~hit;
                state_nxt = (hit && sunk_all) ? GAMEOVER : TURN;
            end
            GAMEOVER: begin
                if (new_game) begin
                    state_nxt = PLACE_A;
                end
            end
            default: state_nxt = PLACE_A;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_a     <= 1'b0;
            load_b     <= 1'b0;
            shot_err   <= 1'b0;
            target_out <= '0;
            fleet_out  <= '0;
            snap       <= '0;
            hist_a     <= '0;
            hist_b     <= '0;
            lat_cnt    <= '0;
            turn       <= 1'b0;
            shots_a    <= '0;
            shots_b    <= '0;
            hits_a     <= '0;
            hits_b     <= '0;
            winner     <= '0;
        end else begin
            load_a   <= 1'b0;
            load_b   <= 1'b0;
            shot_err <= place_bad | fire_bad;

            if (place_ok) begin
                fleet_out <= fleet_in;
                load_a    <= (state == PLACE_A);
                load_b    <= (state == PLACE_B);
                if (state == PLACE_B) begin
                    turn <= 1'b0;
                end
            end

            if (fire_ok) begin
                target_out <= target_in;
                snap       <= turn ? board_a : board_b;
            end

            if (state == FIRE) begin
                lat_cnt <= '0;
                if (turn) begin
                    hist_b  <= hist_b | target_out;
                    shots_b <= shots_b + 6'd1;
                end else begin
                    hist_a  <= hist_a | target_out;
                    shots_a <= shots_a + 6'd1;
                end
            end

            if (state == WAIT) begin
                lat_cnt <= lat_cnt + LW'(1);
            end

            if (state == RESOLVE) begin
                if (hit) begin
                    if (turn) begin
                        hits_b <= hits_b + 6'd1;
                    end else begin
                        hits_a <= hits_a + 6'd1;
                    end
                end
                if (hit && sunk_all) begin
                    winner <= turn ? 2'b10 : 2'b01;
                end else if (!(HIT_AGAIN && hit)) begin
                    turn <= ~turn;
                end
            end

            if ((state == GAMEOVER) && new_game) begin
                target_out <= '0;
                snap       <= '0;
                hist_a     <= '0;
                hist_b     <= '0;
                turn       <= 1'b0;
                shots_a    <= '0;
                shots_b    <= '0;
                hits_a     <= '0;
                hits_b     <= '0;
                winner     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
module tb_battleship_turn_ctrl;

    localparam int unsigned CELLS = 36;

    logic clk = 1'b0;
    logic reset;

    logic             place_req [2];
    logic             fire_req  [2];
    logic             new_game  [2];
    logic [CELLS-1:0] fleet_in  [2];
    logic [CELLS-1:0] target_in [2];
    logic [CELLS-1:0] board_a   [2];
    logic [CELLS-1:0] board_b   [2];

    logic             load_a    [2];
    logic             load_b    [2];
    logic             fire_a    [2];
    logic             fire_b    [2];
    logic             turn      [2];
    logic             last_hit  [2];
    logic             last_miss [2];
    logic             shot_err  [2];
    logic [CELLS-1:0] target_out[2];
    logic [CELLS-1:0] fleet_out [2];
    logic [5:0]       shots_a   [2];
    logic [5:0]       shots_b   [2];
    logic [5:0]       hits_a    [2];
    logic [5:0]       hits_b    [2];
    logic [1:0]       winner    [2];
    logic [2:0]       phase     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    battleship_turn_ctrl #(.CELLS(CELLS), .RESULT_LAT(2), .HIT_AGAIN(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .place_req(place_req[0]), .fleet_in(fleet_in[0]),
        .fire_req(fire_req[0]), .target_in(target_in[0]), .new_game(new_game[0]),
        .board_a(board_a[0]), .board_b(board_b[0]),
        .load_a(load_a[0]), .load_b(load_b[0]), .fire_a(fire_a[0]), .fire_b(fire_b[0]),
        .target_out(target_out[0]), .fleet_out(fleet_out[0]), .turn(turn[0]),
        .last_hit(last_hit[0]), .last_miss(last_miss[0]), .shot_err(shot_err[0]),
        .shots_a(shots_a[0]), .shots_b(shots_b[0]), .hits_a(hits_a[0]), .hits_b(hits_b[0]),
        .winner(winner[0]), .phase(phase[0])
    );

    battleship_turn_ctrl #(.CELLS(CELLS), .RESULT_LAT(2), .HIT_AGAIN(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .place_req(place_req[1]), .fleet_in(fleet_in[1]),
        .fire_req(fire_req[1]), .target_in(target_in[1]), .new_game(new_game[1]),
        .board_a(board_a[1]), .board_b(board_b[1]),
        .load_a(load_a[1]), .load_b(load_b[1]), .fire_a(fire_a[1]), .fire_b(fire_b[1]),
        .target_out(target_out[1]), .fleet_out(fleet_out[1]), .turn(turn[1]),
        .last_hit(last_hit[1]), .last_miss(last_miss[1]), .shot_err(shot_err[1]),
        .shots_a(shots_a[1]), .shots_b(shots_b[1]), .hits_a(hits_a[1]), .hits_b(hits_b[1]),
        .winner(winner[1]), .phase(phase[1])
    );

    // Stand-in for the two hit_or_miss instances: load copies the fleet,
    // a fire strobe removes the targeted cell one cycle later.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                board_a[d] <= '0;
                board_b[d] <= '0;
            end else begin
                if (load_a[d]) board_a[d] <= fleet_out[d];
                if (load_b[d]) board_b[d] <= fleet_out[d];
                if (fire_a[d]) board_a[d] <= board_a[d] & ~target_out[d];
                if (fire_b[d]) board_b[d] <= board_b[d] & ~target_out[d];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input int d, input logic [CELLS-1:0] fa, input logic [CELLS-1:0] fb);
        place_req[d] = 1'b1;
        fleet_in[d]  = fa;
        tick();
        check("load_a_pulse", 64'(load_a[d]), 64'd1);
        check("place_a_fleet", 64'(fleet_out[d]), 64'(fa));
        check("phase_place_b", 64'(phase[d]), 64'd1);
        fleet_in[d] = fb;
        tick();
        place_req[d] = 1'b0;
        check("load_a_end", 64'(load_a[d]), 64'd0);
        check("load_b_pulse", 64'(load_b[d]), 64'd1);
        check("place_b_fleet", 64'(fleet_out[d]), 64'(fb));
        check("phase_turn", 64'(phase[d]), 64'd2);
        tick();
        check("load_b_end", 64'(load_b[d]), 64'd0);
        check("turn_after_place", 64'(turn[d]), 64'd0);
    endtask

    // Accepted shot: strobe one cycle after the request, result 4 cycles after.
    task automatic shoot(input int d, input logic [CELLS-1:0] tgt, input bit by_b, input bit exp_hit);
        int n;
        target_in[d] = tgt;
        fire_req[d]  = 1'b1;
        tick();
        fire_req[d] = 1'b0;
        check("fire_strobe", 64'(by_b ? fire_a[d] : fire_b[d]), 64'd1);
        check("fire_other", 64'(by_b ? fire_b[d] : fire_a[d]), 64'd0);
        check("target_out", 64'(target_out[d]), 64'(tgt));
        n = 1;
        while (!(last_hit[d] || last_miss[d]) && n < 12) begin
            tick();
            n++;
        end
        check("result_latency", 64'(n), 64'd4);
        check("last_hit", 64'(last_hit[d]), 64'(exp_hit));
        check("last_miss", 64'(last_miss[d]), 64'(!exp_hit));
        tick();
    endtask

    task automatic reject(input int d, input logic [CELLS-1:0] tgt);
        target_in[d] = tgt;
        fire_req[d]  = 1'b1;
        tick();
        fire_req[d] = 1'b0;
        check("reject_err", 64'(shot_err[d]), 64'd1);
        check("reject_phase", 64'(phase[d]), 64'd2);
        check("reject_no_fire", 64'(fire_a[d] | fire_b[d]), 64'd0);
        tick();
        check("reject_err_end", 64'(shot_err[d]), 64'd0);
        check("reject_no_fire2", 64'(fire_a[d] | fire_b[d]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            place_req[d] = 1'b0;
            fire_req[d]  = 1'b0;
            new_game[d]  = 1'b0;
            fleet_in[d]  = '0;
            target_in[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_phase", 64'(phase[0]), 64'd0);
        check("rst_strobes", 64'({load_a[0], load_b[0], fire_a[0], fire_b[0],
                                  last_hit[0], last_miss[0], shot_err[0]}), 64'd0);
        check("rst_counts", 64'({shots_a[0], shots_b[0], hits_a[0], hits_b[0]}), 64'd0);
        check("rst_misc", 64'({winner[0], turn[0]}), 64'd0);
        check("rst_vectors", 64'(target_out[0] | fleet_out[0]), 64'd0);
        reset = 1'b1;
        tick();

        // Fleets A=1, B=3; A hits cell 0 of B
        place(0, 36'h1, 36'h3);
        shoot(0, 36'h1, 1'b0, 1'b1);
        check("hits_a_1", 64'(hits_a[0]), 64'd1);
        check("shots_a_1", 64'(shots_a[0]), 64'd1);
        check("turn_to_b", 64'(turn[0]), 64'd1);

        // B misses A, then A repeats a cell
        shoot(0, 36'h2, 1'b1, 1'b0);
        check("turn_to_a", 64'(turn[0]), 64'd0);
        check("shots_b_1", 64'(shots_b[0]), 64'd1);
        check("hits_b_0", 64'(hits_b[0]), 64'd0);
        reject(0, 36'h1);
        check("shots_a_hold", 64'(shots_a[0]), 64'd1);

        // Malformed targets, then the winning shot
        reject(0, 36'h0);
        reject(0, 36'h3);
        shoot(0, 36'h2, 1'b0, 1'b1);
        check("winner_a", 64'(winner[0]), 64'd1);
        check("phase_over", 64'(phase[0]), 64'd6);
        check("hits_a_2", 64'(hits_a[0]), 64'd2);
        check("shots_a_2", 64'(shots_a[0]), 64'd2);
        target_in[0] = 36'h4;
        fire_req[0]  = 1'b1;
        tick();
        fire_req[0] = 1'b0;
        check("over_ignore_phase", 64'(phase[0]), 64'd6);
        check("over_ignore_fire", 64'(fire_a[0] | fire_b[0] | shot_err[0]), 64'd0);
        tick();
        check("over_frozen", 64'(shots_a[0]), 64'd2);

        new_game[0] = 1'b1;
        tick();
        new_game[0] = 1'b0;
        check("ng_phase", 64'(phase[0]), 64'd0);
        check("ng_counts", 64'({shots_a[0], shots_b[0], hits_a[0], hits_b[0]}), 64'd0);
        check("ng_winner_turn", 64'({winner[0], turn[0]}), 64'd0);
        check("ng_target", 64'(target_out[0]), 64'd0);

        // HIT_AGAIN=1 instance: empty fleet rejected, hit keeps turn, miss toggles
        place_req[1] = 1'b1;
        fleet_in[1]  = '0;
        tick();
        place_req[1] = 1'b0;
        check("empty_fleet_err", 64'(shot_err[1]), 64'd1);
        check("empty_fleet_phase", 64'(phase[1]), 64'd0);
        check("empty_fleet_load", 64'(load_a[1]), 64'd0);
        tick();
        place(1, 36'h3, 36'h1);
        shoot(1, 36'h4, 1'b0, 1'b0);
        check("ha_miss_toggle", 64'(turn[1]), 64'd1);
        shoot(1, 36'h1, 1'b1, 1'b1);
        check("ha_hit_keep", 64'(turn[1]), 64'd1);
        check("ha_hits_b", 64'(hits_b[1]), 64'd1);
        shoot(1, 36'h2, 1'b1, 1'b1);
        check("ha_winner_b", 64'(winner[1]), 64'd2);
        check("ha_phase_over", 64'(phase[1]), 64'd6);

        // Reset in the middle of WAIT
        place(0, 36'h1, 36'h3);
        target_in[0] = 36'h1;
        fire_req[0]  = 1'b1;
        tick();
        fire_req[0] = 1'b0;
        tick();
        check("pre_rst_wait", 64'(phase[0]), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_phase", 64'(phase[0]), 64'd0);
        check("async_rst_out", 64'({fire_a[0], fire_b[0], last_hit[0], last_miss[0],
                                    turn[0], shots_a[0]}), 64'd0);
        check("async_rst_target", 64'(target_out[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | fire_a[0] | fire_b[0] | last_hit[0] | last_miss[0];
        end
        check("no_strobe_after_rst", 64'(seen), 64'd0);
        check("post_rst_phase", 64'(phase[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
